// File: rtl/sd_card_cmd_responder_pkg.sv
// -----------------------------------------------------------------------------
// sd_card_cmd_responder_pkg
//   Shared constants, state encoding and the CRC7 step function for the
//   card-side SD CMD line responder.
// -----------------------------------------------------------------------------
package sd_card_cmd_responder_pkg;

    // Frame geometry: 48 bits per command/response. CRC7 covers bits 1..40.
    localparam int         SD_CMD_FRAME_LEN = 48;
    localparam int         SD_CRC_LAST_BIT  = 40;

    // Generator x^7 + x^3 + 1, with the x^7 term implicit.
    localparam logic [6:0] SD_CRC7_POLY     = 7'h09;

    // Response-type codes presented by card logic on resp_type.
    localparam logic [1:0] SD_RESP_NONE     = 2'b00;
    localparam logic [1:0] SD_RESP_R1       = 2'b01;
    localparam logic [1:0] SD_RESP_R3       = 2'b10;
    localparam logic [1:0] SD_RESP_NONE_ALT = 2'b11;

    // R3 replaces the index and CRC fields with all-ones.
    localparam logic [5:0] SD_R3_INDEX      = 6'h3F;
    localparam logic [6:0] SD_R3_CRC        = 7'h7F;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RX       = 3'd1,
        ST_WAIT_NCR = 3'd2,
        ST_TX       = 3'd3,
        ST_GAP_NRC  = 3'd4
    } state_e;

    // One serial CRC7 step, MSB-first data.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
    endfunction

    // True for the response types that put a frame on the line.
    function automatic logic resp_drives_line(input logic [1:0] resp_type);
        return (resp_type == SD_RESP_R1) || (resp_type == SD_RESP_R3);
    endfunction

endpackage

// File: rtl/sd_card_cmd_responder_crc7.sv
// -----------------------------------------------------------------------------
// sd_card_cmd_responder_crc7
//   Serial CRC7 accumulator (G = x^7 + x^3 + 1, init 0).
//   Ports:
//     clk, rst   clock, asynchronous active-high reset
//     clr        synchronous clear to zero (wins over en)
//     en         fold bit_in into the CRC this clock
//     bit_in     serial data bit, MSB first
//     crc        accumulated CRC (registered)
//     crc_next   CRC including bit_in (combinational), for callers that need
//                the final value in the same cycle as the last data bit
// -----------------------------------------------------------------------------
module sd_card_cmd_responder_crc7
    import sd_card_cmd_responder_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [6:0] crc,
    output logic [6:0] crc_next
);

    always_comb begin
        crc_next = crc7_step(crc, bit_in);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= crc_next;
        end
    end

endmodule

// File: rtl/sd_card_cmd_responder.sv
// -----------------------------------------------------------------------------
// sd_card_cmd_responder
//   Card-side end of the SD CMD line. Deserialises 48-bit host commands,
//   checks transmission/end bits and CRC7, presents index/argument to card
//   logic, then serialises an R1-style or R3 response N_CR clocks after the
//   command end bit, followed by an N_RC-clock dead gap.
//   Parameters:
//     N_CR   clocks from command end bit to response start bit (>= 2)
//     N_RC   idle clocks after a frame before a new start bit is accepted
//   Ports:
//     clk, rst      card clock, asynchronous active-high reset
//     cmd_in        sampled CMD line (idle high)
//     cmd_out       driven CMD bit
//     cmd_oe        1 = responder drives the CMD line
//     cmd_valid     1-clock pulse: good command received
//     cmd_index     index of last good command
//     cmd_arg       argument of last good command
//     resp_type     00/11 none, 01 R1-style, 10 R3 (sampled in cmd_valid cycle)
//     resp_arg      response payload (sampled in cmd_valid cycle)
//     crc_err       1-clock pulse: CRC7 mismatch
//     frame_err     1-clock pulse: transmission bit or end bit was 0
//     busy          1 from start bit until the FSM returns to IDLE
// -----------------------------------------------------------------------------
module sd_card_cmd_responder
    import sd_card_cmd_responder_pkg::*;
#(
    parameter int N_CR = 2,
    parameter int N_RC = 8
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_in,
    output logic        cmd_out,
    output logic        cmd_oe,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    input  logic [1:0]  resp_type,
    input  logic [31:0] resp_arg,
    output logic        crc_err,
    output logic        frame_err,
    output logic        busy
);

    if (N_CR < 2) begin : g_bad_ncr
        $error("sd_card_cmd_responder: N_CR must be >= 2");
    end

    localparam logic [5:0] FRAME_LAST = 6'(SD_CMD_FRAME_LEN);
    localparam logic [5:0] CRC_LAST   = 6'(SD_CRC_LAST_BIT);
    localparam logic [5:0] NCR_LAST   = 6'(N_CR - 1);
    localparam logic [5:0] NRC_LAST   = 6'(N_RC);

    state_e      state;
    // One counter serves every phase: bits received (RX), clocks since the
    // end bit (WAIT_NCR), bit number on the line (TX), gap clock (GAP_NRC).
    logic [5:0]  cnt;
    // Bits 3..47 of the incoming frame; bit 2 is only checked, never stored.
    logic [44:0] rx_shift;
    // Bits still to transmit after the one currently on cmd_out.
    logic [46:0] tx_shift;
    // Splice the live CRC into the response (R1-style) instead of a fixed field.
    logic        tx_crc_en;

    logic [5:0]  rx_bit_num;
    logic        rx_crc_ok;
    logic        crc_clr;
    logic        crc_en;
    logic        crc_bit;
    logic [6:0]  crc;
    logic [6:0]  crc_next;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        rx_bit_num = cnt + 6'd1;
        crc_clr    = 1'b0;
        crc_en     = 1'b0;
        crc_bit    = cmd_in;
        case (state)
            // The start bit is 0 and folds into a zero CRC as zero, so holding
            // the CRC cleared through IDLE already accounts for bit 1.
            ST_IDLE:     crc_clr = 1'b1;
            ST_RX:       crc_en  = (rx_bit_num <= CRC_LAST);
            ST_WAIT_NCR: crc_clr = 1'b1;
            ST_TX: begin
                crc_en  = (cnt <= CRC_LAST);
                crc_bit = cmd_out;
            end
            default: ;
        endcase
    end

    // At the end-bit edge the CRC holds bits 1..40 and rx_shift[6:0] holds
    // the received CRC field (bits 41..47).
    assign rx_crc_ok = (rx_shift[6:0] == crc);

    // RX and TX never overlap, so one accumulator serves both directions.
    sd_card_cmd_responder_crc7 u_crc7 (
        .clk      (clk),
        .rst      (rst),
        .clr      (crc_clr),
        .en       (crc_en),
        .bit_in   (crc_bit),
        .crc      (crc),
        .crc_next (crc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            tx_crc_en <= 1'b0;
            cmd_out   <= 1'b1;
            cmd_oe    <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_index <= '0;
            cmd_arg   <= '0;
            crc_err   <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            crc_err   <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (!cmd_in) begin
                        state <= ST_RX;
                        busy  <= 1'b1;
                        cnt   <= 6'd1;
                    end
                end

                ST_RX: begin
                    rx_shift <= {rx_shift[43:0], cmd_in};
                    cnt      <= rx_bit_num;
                    if (rx_bit_num == 6'd2 && !cmd_in) begin
                        frame_err <= 1'b1;
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        cnt       <= '0;
                    end else if (rx_bit_num == FRAME_LAST) begin
                        if (!cmd_in) begin
                            // A bad end bit is reported even if the CRC is also wrong.
                            frame_err <= 1'b1;
                            state     <= ST_IDLE;
                            busy      <= 1'b0;
                            cnt       <= '0;
                        end else if (!rx_crc_ok) begin
                            crc_err <= 1'b1;
                            state   <= ST_IDLE;
                            busy    <= 1'b0;
                            cnt     <= '0;
                        end else begin
                            cmd_valid <= 1'b1;
                            cmd_index <= rx_shift[44:39];
                            cmd_arg   <= rx_shift[38:7];
                            state     <= ST_WAIT_NCR;
                            cnt       <= 6'd1;
                        end
                    end
                end

                ST_WAIT_NCR: begin
                    // cnt == 1 is the cmd_valid cycle: card logic answers here.
                    if (cnt == 6'd1 && !resp_drives_line(resp_type)) begin
                        // The cmd_valid cycle already counts as the first gap clock.
                        if (N_RC <= 1) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            cnt   <= '0;
                        end else begin
                            state <= ST_GAP_NRC;
                            cnt   <= 6'd2;
                        end
                    end else begin
                        if (cnt == 6'd1) begin
                            if (resp_type == SD_RESP_R3) begin
                                tx_shift  <= {1'b0, SD_R3_INDEX, resp_arg, SD_R3_CRC, 1'b1};
                                tx_crc_en <= 1'b0;
                            end else begin
                                tx_shift  <= {1'b0, cmd_index, resp_arg, 7'h00, 1'b1};
                                tx_crc_en <= 1'b1;
                            end
                        end
                        if (cnt == NCR_LAST) begin
                            state   <= ST_TX;
                            cnt     <= 6'd1;
                            cmd_oe  <= 1'b1;
                            cmd_out <= 1'b0;
                        end else begin
                            cnt <= cnt + 6'd1;
                        end
                    end
                end

                ST_TX: begin
                    if (cnt == FRAME_LAST) begin
                        cmd_oe  <= 1'b0;
                        cmd_out <= 1'b1;
                        if (N_RC == 0) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            cnt   <= '0;
                        end else begin
                            state <= ST_GAP_NRC;
                            cnt   <= 6'd1;
                        end
                    end else begin
                        cnt <= cnt + 6'd1;
                        if (cnt == CRC_LAST && tx_crc_en) begin
                            // crc_next already includes bit 40 on the line now.
                            cmd_out  <= crc_next[6];
                            tx_shift <= {crc_next[5:0], 1'b1, 40'b0};
                        end else begin
                            cmd_out  <= tx_shift[46];
                            tx_shift <= {tx_shift[45:0], 1'b0};
                        end
                    end
                end

                ST_GAP_NRC: begin
                    if (cnt >= NRC_LAST) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// -----------------------------------------------------------------------------
// tb_sd_card_cmd_responder
//   Directed bench for the card-side CMD responder. Frames and expected
//   responses are hand-computed constants. Inputs change 1 time unit after
//   the rising edge; outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_sd_card_cmd_responder;

    localparam int N_CR = 2;
    localparam int N_RC = 8;

    // Hand-computed frames (CRC7 of 40'h4000000000 = 7'h4A, of 40'h48000001AA = 7'h43).
    localparam logic [47:0] CMD0_FRAME      = 48'h40_00000000_95;
    localparam logic [47:0] CMD0_END0_FRAME = 48'h40_00000000_94;
    localparam logic [47:0] CMD8_FRAME      = 48'h48_000001AA_87;
    localparam logic [47:0] CMD8_BADCRC     = 48'h48_000001AA_89;
    // CRC7 of 40'h08000001AA = 7'h09 -> last byte 8'h13.
    localparam logic [47:0] R7_EXPECTED     = 48'h08_000001AA_13;
    localparam logic [31:0] R3_ARG          = 32'h00FF_8000;
    localparam logic [47:0] R3_EXPECTED     = 48'h3F_00FF8000_FF;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_in;
    logic        cmd_out;
    logic        cmd_oe;
    logic        cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic [1:0]  resp_type;
    logic [31:0] resp_arg;
    logic        crc_err;
    logic        frame_err;
    logic        busy;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Event counters, written only by the negedge monitor.
    int oe_cycles    = 0;
    int valid_pulses = 0;
    int err_pulses   = 0;

    always #5 clk = ~clk;

    sd_card_cmd_responder #(.N_CR(N_CR), .N_RC(N_RC)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_in    (cmd_in),
        .cmd_out   (cmd_out),
        .cmd_oe    (cmd_oe),
        .cmd_valid (cmd_valid),
        .cmd_index (cmd_index),
        .cmd_arg   (cmd_arg),
        .resp_type (resp_type),
        .resp_arg  (resp_arg),
        .crc_err   (crc_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always @(negedge clk) begin
        if (cmd_oe)               oe_cycles    <= oe_cycles + 1;
        if (cmd_valid)            valid_pulses <= valid_pulses + 1;
        if (crc_err || frame_err) err_pulses   <= err_pulses + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives a 48-bit frame MSB first; returns 1 unit after the end-bit edge
    // with the line released high.
    task automatic send_frame(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            cmd_in = f[i];
            tick(1);
        end
        cmd_in = 1'b1;
    endtask

    // Captures 48 response bits, starting with the start bit currently on the line.
    task automatic get_resp(output logic [47:0] r, output int oe_hi);
        oe_hi = 0;
        for (int i = 47; i >= 0; i--) begin
            r[i] = cmd_out;
            if (cmd_oe) oe_hi++;
            tick(1);
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [47:0] resp;
        int          oe_hi;
        int          snap_oe;
        int          snap_valid;
        int          snap_err;

        rst       = 1'b1;
        cmd_in    = 1'b1;
        resp_type = 2'b00;
        resp_arg  = '0;
        tick(3);

        // Reset state
        check_eq("rst_cmd_out", cmd_out, 1);
        check_eq("rst_cmd_oe", cmd_oe, 0);
        check_eq("rst_flags", {cmd_valid, crc_err, frame_err, busy}, 0);
        check_eq("rst_index_arg", {cmd_index, cmd_arg}, 0);
        rst = 1'b0;
        tick(2);

        // CMD0, no response: cmd_valid at t+1, line never driven, busy drops after N_RC
        snap_oe = oe_cycles;
        send_frame(CMD0_FRAME);
        check_eq("cmd0_valid", cmd_valid, 1);
        check_eq("cmd0_index", cmd_index, 6'd0);
        check_eq("cmd0_arg", cmd_arg, 32'd0);
        check_eq("cmd0_busy", busy, 1);
        tick(N_RC - 1);
        check_eq("cmd0_busy_before_gap_end", busy, 1);
        tick(1);
        check_eq("cmd0_busy_after_gap", busy, 0);
        check_eq("cmd0_no_drive", oe_cycles - snap_oe, 0);
        tick(2);

        // CMD8, R1-style response
        resp_type = 2'b01;
        resp_arg  = 32'h0000_01AA;
        send_frame(CMD8_FRAME);
        check_eq("cmd8_valid", cmd_valid, 1);
        check_eq("cmd8_index", cmd_index, 6'd8);
        check_eq("cmd8_arg", cmd_arg, 32'h0000_01AA);
        check_eq("cmd8_oe_before_ncr", cmd_oe, 0);
        tick(N_CR - 1);
        check_eq("cmd8_start_oe", cmd_oe, 1);
        check_eq("cmd8_start_bit", cmd_out, 0);
        get_resp(resp, oe_hi);
        check_eq("cmd8_resp_frame", resp, R7_EXPECTED);
        check_eq("cmd8_oe_cycles", oe_hi, 48);
        check_eq("cmd8_oe_release", {cmd_oe, cmd_out}, 2'b01);
        tick(N_RC - 1);
        check_eq("cmd8_busy_in_gap", busy, 1);
        tick(1);
        check_eq("cmd8_busy_after_gap", busy, 0);
        tick(2);

        // CMD8 with a corrupted CRC byte
        snap_oe    = oe_cycles;
        snap_valid = valid_pulses;
        send_frame(CMD8_BADCRC);
        check_eq("badcrc_crc_err", crc_err, 1);
        check_eq("badcrc_frame_err", frame_err, 0);
        check_eq("badcrc_busy", busy, 0);
        tick(1);
        check_eq("badcrc_pulse_width", crc_err, 0);
        tick(60);
        check_eq("badcrc_no_valid", valid_pulses - snap_valid, 0);
        check_eq("badcrc_no_drive", oe_cycles - snap_oe, 0);
        check_eq("badcrc_index_held", cmd_index, 6'd8);

        // Transmission bit 0 right after the start bit
        cmd_in = 1'b0;
        tick(2);
        cmd_in = 1'b1;
        check_eq("txbit_frame_err", frame_err, 1);
        check_eq("txbit_busy", busy, 0);
        tick(1);
        check_eq("txbit_pulse_width", frame_err, 0);
        tick(3);

        // End bit 0 with a correct CRC field: frame error only
        send_frame(CMD0_END0_FRAME);
        check_eq("endbit_errs", {frame_err, crc_err, cmd_valid}, 3'b100);
        tick(3);

        // R3 response: all-ones index and CRC fields
        resp_type = 2'b10;
        resp_arg  = R3_ARG;
        send_frame(CMD8_FRAME);
        check_eq("r3_valid", cmd_valid, 1);
        tick(N_CR - 1);
        get_resp(resp, oe_hi);
        check_eq("r3_resp_frame", resp, R3_EXPECTED);
        check_eq("r3_oe_cycles", oe_hi, 48);
        tick(N_RC + 1);

        // Reset while the response is on the line (bit 20)
        send_frame(CMD8_FRAME);
        tick(N_CR - 1);
        tick(19);
        check_eq("midtx_driving", cmd_oe, 1);
        rst = 1'b1;
        #1;
        check_eq("midtx_rst_release", {cmd_oe, cmd_out}, 2'b01);
        check_eq("midtx_rst_busy", busy, 0);
        check_eq("midtx_rst_index", cmd_index, 6'd0);
        tick(2);
        rst = 1'b0;
        tick(2);

        // CMD0 after reset, then CMD8 exactly N_RC idle clocks later
        resp_type = 2'b00;
        send_frame(CMD0_FRAME);
        check_eq("postrst_cmd0_valid", cmd_valid, 1);
        check_eq("postrst_cmd0_index", cmd_index, 6'd0);
        tick(N_RC);
        send_frame(CMD8_FRAME);
        check_eq("b2b_cmd8_valid", cmd_valid, 1);
        check_eq("b2b_cmd8_index", cmd_index, 6'd8);
        check_eq("b2b_cmd8_arg", cmd_arg, 32'h0000_01AA);

        // Start bit inside the gap is ignored
        snap_err = err_pulses;
        tick(2);
        cmd_in = 1'b0;
        tick(1);
        cmd_in = 1'b1;
        tick(N_RC);
        check_eq("gap_glitch_busy", busy, 0);
        check_eq("gap_glitch_no_err", err_pulses - snap_err, 0);
        send_frame(CMD0_FRAME);
        check_eq("gap_glitch_next_valid", cmd_valid, 1);
        check_eq("gap_glitch_next_index", cmd_index, 6'd0);
        tick(N_RC + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
